// File: rtl/stage4_memory_access_if.sv
// Data-memory request/grant/response bus between the memory stage
// and the data memory.
interface stage4_memory_access_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/stage4_memory_access.sv
// Memory stage: load/store bus sequencing, lane alignment and
// writeback value selection for RV32I.
module stage4_memory_access #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_immediate,
    input  logic [XLEN-1:0] in_program_counter,
    input  logic [XLEN-1:0] in_rs1_value,
    input  logic [XLEN-1:0] in_rs2_value,
    input  logic [XLEN-1:0] in_alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_rd_value,
    stage4_memory_access_if.master dmem,
    output logic            mem_fault,
    output logic [XLEN-1:0] mem_fault_pc
);
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] ea;
    logic            is_load, is_store, mem_op;
    logic            misalign, bad_f3, fault;
    logic            accept, go_mem;
    logic [3:0]      be_n;
    logic [XLEN-1:0] wdata_n;
    logic [XLEN-1:0] wb_val;
    logic            wb_we;

    logic [XLEN-1:0] addr_q, wdata_q;
    logic [3:0]      be_q;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [1:0]      a_q;
    logic [4:0]      rd_q;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_val;

    assign ea       = in_rs1_value + in_immediate;
    assign is_load  = (in_opcode == OP_LOAD);
    assign is_store = (in_opcode == OP_STORE);
    assign mem_op   = is_load || is_store;

    assign misalign = ((in_funct3[1:0] == 2'b01) && ea[0]) ||
                      ((in_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    assign bad_f3   = is_load ? (in_funct3 == 3'b011 ||
                                 in_funct3 == 3'b110 ||
                                 in_funct3 == 3'b111)
                              : (in_funct3 >= 3'b011);
    assign fault    = mem_op && (bad_f3 || misalign);

    assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign go_mem   = accept && mem_op && !fault;

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = in_rs2_value;
        case (in_funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << ea[1:0];
                wdata_n = {4{in_rs2_value[7:0]}};
            end
            2'b01: begin
                be_n    = 4'b0011 << ea[1:0];
                wdata_n = {2{in_rs2_value[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        wb_val = '0;
        wb_we  = 1'b0;
        unique case (1'b1)
            (in_opcode == OP_REG),
            (in_opcode == OP_IMM): begin
                wb_val = in_alu_result;
                wb_we  = 1'b1;
            end
            (in_opcode == OP_LUI): begin
                wb_val = in_immediate;
                wb_we  = 1'b1;
            end
            (in_opcode == OP_AUIPC): begin
                wb_val = in_program_counter + in_immediate;
                wb_we  = 1'b1;
            end
            (in_opcode == OP_JAL),
            (in_opcode == OP_JALR): begin
                wb_val = in_program_counter + XLEN'(4);
                wb_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dmem.rdata[7:0];
        case (a_q)
            2'd1:    ld_byte = dmem.rdata[15:8];
            2'd2:    ld_byte = dmem.rdata[23:16];
            2'd3:    ld_byte = dmem.rdata[31:24];
            default: ;
        endcase
        ld_half = a_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        ld_val  = dmem.rdata;
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (go_mem) state_d = REQ;
            REQ:      if (dmem.gnt) state_d = we_q ? IDLE : WAIT_RSP;
            WAIT_RSP: if (dmem.rvalid) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Request fields are registered so they stay stable until grant
    assign dmem.req   = (state_q == REQ);
    assign dmem.we    = dmem.req && we_q;
    assign dmem.addr  = addr_q;
    assign dmem.be    = dmem.req ? be_q : 4'b0000;
    assign dmem.wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_rd       <= '0;
            out_rd_we    <= 1'b0;
            out_rd_value <= '0;
            mem_fault    <= 1'b0;
            mem_fault_pc <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            a_q          <= '0;
            rd_q         <= '0;
        end else begin
            mem_fault <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (go_mem) begin
                addr_q  <= {ea[XLEN-1:2], 2'b00};
                be_q    <= be_n;
                wdata_q <= wdata_n;
                we_q    <= is_store;
                f3_q    <= in_funct3;
                a_q     <= ea[1:0];
                rd_q    <= in_rd;
            end else if (accept) begin
                out_valid    <= 1'b1;
                out_rd       <= in_rd;
                out_rd_we    <= !fault && wb_we && (in_rd != 5'd0);
                out_rd_value <= fault ? '0 : wb_val;
                if (fault) begin
                    mem_fault    <= 1'b1;
                    mem_fault_pc <= in_program_counter;
                end
            end
            if (state_q == REQ && dmem.gnt && we_q) begin
                out_valid    <= 1'b1;
                out_rd       <= rd_q;
                out_rd_we    <= 1'b0;
                out_rd_value <= '0;
            end
            if (state_q == WAIT_RSP && dmem.rvalid) begin
                out_valid    <= 1'b1;
                out_rd       <= rd_q;
                out_rd_we    <= (rd_q != 5'd0);
                out_rd_value <= ld_val;
            end
        end
    end
endmodule
